mem_bist_ctrl: RTL and testbench

March C- built-in self-test sequencer for the 128x32 single-port RAM.
- Sits directly upstream of the RAM: drives its we/address/d and consumes its q.
- Runs once per start pulse, then reports pass/fail plus first-failure diagnostics.
- Used at power-up and on demand before the RAM is handed to the datapath.

---
 rtl/mem_bist_pkg.sv | 42 ++++
 rtl/mem_bist_addr_gen.sv | 44 ++++
 rtl/mem_bist_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the March C- RAM self-test sequencer.
// MEM_BIST_CHECKERBOARD_EN selects checkerboard backgrounds instead of solid 0/1.
package mem_bist_pkg;

  // Element states share their encoding with the reported element number.
  typedef enum logic [2:0] {
    ST_M0   = 3'd0,
    ST_M1   = 3'd1,
    ST_M2   = 3'd2,
    ST_M3   = 3'd3,
    ST_M4   = 3'd4,
    ST_M5   = 3'd5,
    ST_IDLE = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  localparam logic [63:0] BG_SOLID   = 64'h0;
  localparam logic [63:0] BG_CHECKER = {32{2'b01}};

`ifdef MEM_BIST_CHECKERBOARD_EN
  localparam logic [63:0] BG0_WORD = BG_CHECKER;
`else
  localparam logic [63:0] BG0_WORD = BG_SOLID;
`endif

  // M0 and M5 touch each address once, M1..M4 twice.
  function automatic int unsigned total_ops(input int unsigned aw);
    return 10 * (1 << aw);
  endfunction

  function automatic logic elem_down(input state_e s);
    return (s == ST_M3) || (s == ST_M4);
  endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Up/down address counter for the BIST sequencer; direction is latched on load
// so the terminal flag always refers to the element currently running.
module mem_bist_addr_gen #(
  parameter int Addr_width = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  down,
  output logic [Addr_width-1:0] addr,
  output logic                  last
);

  localparam logic [Addr_width-1:0] ONE = {{(Addr_width-1){1'b0}}, 1'b1};

  logic [Addr_width-1:0] addr_q, addr_d;
  logic                  dir_q, dir_d;

  assign addr = addr_q;
  assign last = dir_q ? (addr_q == '0) : (addr_q == '1);

  always_comb begin
    addr_d = addr_q;
    dir_d  = dir_q;
    if (load) begin
      dir_d  = down;
      addr_d = down ? '1 : '0;
    end else if (step && !last) begin
      addr_d = dir_q ? addr_q - ONE : addr_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      dir_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      dir_q  <= dir_d;
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March C- self-test sequencer for a single-port RAM, one operation per clock.
// Backgrounds come from mem_bist_pkg (MEM_BIST_CHECKERBOARD_EN selects checkerboard).
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int Data_width = 32,
  parameter int Addr_width = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_we,
  output logic [Addr_width-1:0] mem_address,
  output logic [Data_width-1:0] mem_d,
  input  logic [Data_width-1:0] mem_q,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [Addr_width-1:0] fail_address,
  output logic [Data_width-1:0] fail_data,
  output logic [2:0]            fail_element
);

  localparam logic [Data_width-1:0] B0 = BG0_WORD[Data_width-1:0];
  localparam logic [Data_width-1:0] B1 = ~B0;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [Data_width-1:0] d_q, d_d, exp_q, exp_d;
  logic                  done_q, done_d, pass_q, pass_d;
  logic [Addr_width-1:0] faddr_q, faddr_d;
  logic [Data_width-1:0] fdata_q, fdata_d;
  logic [2:0]            felem_q, felem_d;
  logic                  ag_load, ag_step, ag_down, ag_last, fail_cap;

  function automatic logic [Data_width-1:0] rd_pat(input state_e s);
    return ((s == ST_M2) || (s == ST_M4)) ? B1 : B0;
  endfunction

  function automatic logic [Data_width-1:0] wr_pat(input state_e s);
    return ((s == ST_M1) || (s == ST_M3)) ? B1 : B0;
  endfunction

  mem_bist_addr_gen #(.Addr_width(Addr_width)) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (ag_load),
    .step (ag_step),
    .down (ag_down),
    .addr (mem_address),
    .last (ag_last)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    d_d      = d_q;
    exp_d    = exp_q;
    done_d   = done_q;
    pass_d   = pass_q;
    faddr_d  = faddr_q;
    fdata_d  = fdata_q;
    felem_d  = felem_q;
    ag_load  = 1'b0;
    ag_step  = 1'b0;
    ag_down  = 1'b0;
    fail_cap = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        we_d = 1'b0;
        if (start) begin
          state_d = ST_M0;
          ag_load = 1'b1;
          we_d    = 1'b1;
          d_d     = B0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          faddr_d = '0;
          fdata_d = '0;
          felem_d = '0;
        end
      end
      ST_M0: begin
        if (!ag_last) begin
          ag_step = 1'b1;
        end else begin
          state_d = ST_M1;
          ag_load = 1'b1;
          we_d    = 1'b0;
          exp_d   = B0;
        end
      end
      ST_M5: begin
        if (mem_q != exp_q) begin
          fail_cap = 1'b1;
        end else if (!ag_last) begin
          ag_step = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
          we_d    = 1'b0;
        end
      end
      default: begin
        // M1..M4: read then write at each address.
        if (!we_q) begin
          if (mem_q != exp_q) begin
            fail_cap = 1'b1;
          end else begin
            we_d = 1'b1;
            d_d  = wr_pat(state_q);
          end
        end else if (!ag_last) begin
          ag_step = 1'b1;
          we_d    = 1'b0;
          exp_d   = rd_pat(state_q);
        end else begin
          state_d = state_e'(state_q + 3'd1);
          ag_load = 1'b1;
          ag_down = elem_down(state_d);
          we_d    = 1'b0;
          exp_d   = rd_pat(state_d);
        end
      end
    endcase
    if (fail_cap) begin
      state_d = ST_DONE;
      we_d    = 1'b0;
      done_d  = 1'b1;
      pass_d  = 1'b0;
      faddr_d = mem_address;
      fdata_d = mem_q;
      felem_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      d_q     <= '0;
      exp_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      felem_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      d_q     <= d_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      felem_q <= felem_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_d        = d_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_address = faddr_q;
  assign fail_data    = fdata_q;
  assign fail_element = felem_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl: a behavioural March C- model predicts the
// operation trace and final verdict for a RAM model with injectable faults.
module tb_mem_bist_ctrl;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int N  = 128;
`ifdef MEM_BIST_CHECKERBOARD_EN
  localparam logic [31:0] B0 = 32'h5555_5555;
`else
  localparam logic [31:0] B0 = 32'h0000_0000;
`endif
  localparam logic [31:0] B1 = ~B0;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          mem_we, busy, done, pass;
  logic [AW-1:0] mem_address, fail_address;
  logic [DW-1:0] mem_d, mem_q, fail_data;
  logic [2:0]    fail_element;

  always #5 clk = ~clk;

  mem_bist_ctrl #(.Data_width(DW), .Addr_width(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_we(mem_we), .mem_address(mem_address), .mem_d(mem_d), .mem_q(mem_q),
    .busy(busy), .done(done), .pass(pass),
    .fail_address(fail_address), .fail_data(fail_data), .fail_element(fail_element)
  );

  // Fault configuration: a stuck bit on one address, and/or an overwrite after M2.
  bit          st_en, fc_en;
  logic [6:0]  st_addr, fc_addr;
  logic [4:0]  st_bit;
  logic        st_val;
  logic [31:0] fc_val;

  logic [31:0] mem [N];
  int          opcnt;

  always_comb begin
    mem_q = mem[mem_address];
    if (st_en && mem_address == st_addr) mem_q[st_bit] = st_val;
  end

  always @(posedge clk) begin
    if (!busy) opcnt <= 0;
    else       opcnt <= opcnt + 1;
    if (busy && mem_we) mem[mem_address] <= mem_d;
    if (busy && fc_en && opcnt + 1 == 5 * N) mem[fc_addr] <= fc_val;
  end

  typedef struct packed {
    logic        we;
    logic [6:0]  a;
    logic [31:0] d;
  } op_t;

  typedef struct {
    bit          pass;
    int          fa;
    logic [31:0] fd;
    int          fe;
    int          nops;
    int          nwr;
  } res_t;

  op_t  exp_ops[$];
  res_t exp_res[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] rd_exp(input int e);
    return (e == 2 || e == 4) ? B1 : B0;
  endfunction

  function automatic logic [31:0] wr_val(input int e);
    return (e == 1 || e == 3) ? B1 : B0;
  endfunction

  // March C- over a plain array with the same fault applied; stops on first mismatch.
  task automatic model_run();
    logic [31:0] m [N];
    res_t r;
    bit   stop;
    op_t  o;
    r.pass = 1'b1; r.fa = 0; r.fd = '0; r.fe = 0; r.nops = 0; r.nwr = 0;
    stop = 1'b0;
    for (int e = 0; e < 6 && !stop; e++) begin
      for (int i = 0; i < N && !stop; i++) begin
        int a;
        logic [31:0] v;
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (e > 0) begin
          v = m[a];
          if (st_en && 7'(a) == st_addr) v[st_bit] = st_val;
          o.we = 1'b0; o.a = 7'(a); o.d = '0;
          exp_ops.push_back(o);
          r.nops++;
          if (v !== rd_exp(e)) begin
            r.pass = 1'b0; r.fa = a; r.fd = v; r.fe = e;
            stop = 1'b1;
          end
        end
        if (!stop && e < 5) begin
          o.we = 1'b1; o.a = 7'(a); o.d = wr_val(e);
          exp_ops.push_back(o);
          m[a] = wr_val(e);
          r.nops++;
          r.nwr++;
        end
      end
      if (e == 2 && fc_en && !stop) m[fc_addr] = fc_val;
    end
    exp_res.push_back(r);
  endtask

  // Monitor: checks every busy cycle's operation and the verdict when done rises.
  bit   in_run = 1'b0;
  int   cyc, wr;
  op_t  mo;
  res_t mr;
  initial begin
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!in_run) begin in_run = 1'b1; cyc = 0; wr = 0; end
        cyc++;
        if (mem_we) wr++;
        if (exp_ops.size() == 0) begin
          check("unexpected_op", {mem_we, mem_address}, 64'h0);
        end else begin
          mo = exp_ops.pop_front();
          check("op", {mem_we, mem_address, mem_we ? mem_d : 32'h0}, mo);
        end
      end else if (done && in_run) begin
        in_run = 1'b0;
        if (exp_res.size() == 0) begin
          check("unexpected_done", 64'h1, 64'h0);
        end else begin
          mr = exp_res.pop_front();
          check("pass",         pass,         mr.pass);
          check("fail_address", fail_address, mr.fa);
          check("fail_data",    fail_data,    mr.fd);
          check("fail_element", fail_element, mr.fe);
          check("op_cycles",    cyc,          mr.nops);
          check("write_cycles", wr,           mr.nwr);
        end
      end else if (!done) begin
        in_run = 1'b0;
      end
    end
  end

  task automatic set_fault(input bit se, input int sa, input int sb, input bit sv,
                           input bit fe, input int fa, input logic [31:0] fv);
    st_en = se; st_addr = 7'(sa); st_bit = 5'(sb); st_val = sv;
    fc_en = fe; fc_addr = 7'(fa); fc_val = fv;
  endtask

  task automatic launch();
    model_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("status_cleared", {done, pass, fail_address, fail_data, fail_element}, 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_reached", done, 1);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    set_fault(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    start = 1'b0;
    #1;
    check("reset_ctrl", {mem_we, mem_address, busy, done, pass, fail_address, fail_element}, 0);
    check("reset_data", {mem_d, fail_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fault-free run.
    launch();
    wait_done();

    // Stuck-at-1 on bit 5 of 0x2A; then a clean run clears the failure status.
    set_fault(1, 'h2A, 5, 1, 0, 0, 0);
    launch();
    wait_done();
    set_fault(0, 0, 0, 0, 0, 0, 0);
    launch();
    wait_done();

    // Word at 0x7F overwritten after M2.
    set_fault(0, 0, 0, 0, 1, 'h7F, 32'hFFFF_FFFF);
    launch();
    wait_done();

    // Reset partway into M2 aborts immediately, then a fresh run passes.
    set_fault(0, 0, 0, 0, 0, 0, 0);
    launch();
    repeat (500) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ctrl", {mem_we, mem_address, busy, done, pass, fail_address, fail_element}, 0);
    check("abort_data", {mem_d, fail_data}, 0);
    exp_ops.delete();
    exp_res.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_abort", {busy, done}, 0);
    launch();
    wait_done();

    // Start held high for the whole run must not restart it.
    model_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("busy_held_start", busy, 1);
    wait_done();

    // Randomized faults.
    for (int t = 0; t < 6; t++) begin
      case ($urandom_range(0, 2))
        0: set_fault(0, 0, 0, 0, 0, 0, 0);
        1: set_fault(1, $urandom_range(0, N - 1), $urandom_range(0, 31),
                     1'($urandom_range(0, 1)), 0, 0, 0);
        default: set_fault(0, 0, 0, 0, 1, $urandom_range(0, N - 1), $urandom);
      endcase
      launch();
      wait_done();
    end

    check("ops_drained", exp_ops.size(), 0);
    check("results_drained", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
